// File: rtl/uart_boot_loader_pkg.sv
// Shared encodings and frame-format constants for the UART boot loader.
// The frame on the wire is: sync byte, 16-bit big-endian length, then little-endian 32-bit words.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned LEN_BYTES        = 2;
  localparam int unsigned BYTES_PER_WORD   = 4;

  // A frame may fill IMEM exactly, but never exceed it.
  function automatic logic len_too_big(input logic [15:0] len, input int unsigned addr_w);
    return {1'b0, len} > (17'd1 << addr_w);
  endfunction

endpackage

// File: rtl/uart_boot_loader_timer.sv
// Inter-byte watchdog: counts while enabled, clears on any received byte,
// and flags expiry on the cycle the count reaches TIMEOUT_CLKS-1.
module boot_timeout_timer
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 807300
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_boot_loader.sv
// Parses a framed UART byte stream into 32-bit words and writes them to IMEM,
// holding the core in reset until a complete image has been loaded.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [7:0]        SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned       TIMEOUT_CLKS = 807300
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Start,
  output logic              o_Mem_Req,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [31:0]       o_Mem_Wdata,
  input  logic              i_Mem_Ack,
  output logic              o_Cpu_Hold,
  output logic              o_Done,
  output logic              o_Error,
  output logic [15:0]       o_Word_Count
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  state_e            state_q;
  logic [15:0]       len_q, count_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              req_q, hold_q, done_q, error_q;
  logic              pend_vld_q;
  logic [7:0]        pend_byte_q;

  logic              timer_en, timer_exp;
  logic              data_vld;
  logic [7:0]        data_byte;
  logic [15:0]       len_full, count_inc;

  assign timer_en = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);

  boot_timeout_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk_i   (i_Clock),
    .rst_ni  (i_Rst_n),
    .clr_i   (i_Rx_DV),
    .en_i    (timer_en),
    .expire_o(timer_exp)
  );

  // The skid byte caught during a write is consumed ahead of any live strobe.
  assign data_vld  = pend_vld_q | i_Rx_DV;
  assign data_byte = pend_vld_q ? pend_byte_q : i_Rx_Byte;
  assign len_full  = {len_q[15:8], i_Rx_Byte};
  assign count_inc = count_q + 16'd1;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_SYNC;
      len_q       <= '0;
      count_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= '0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_q <= ST_LEN_HI;
        end
        ST_LEN_HI: begin
          if (i_Rx_DV) begin
            len_q[15:8] <= i_Rx_Byte;
            state_q     <= ST_LEN_LO;
          end else if (timer_exp) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (i_Rx_DV) begin
            len_q <= len_full;
            if (len_full == 16'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else if (len_too_big(len_full, ADDR_W)) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              state_q    <= ST_DATA;
              byte_idx_q <= '0;
              count_q    <= '0;
              addr_q     <= BASE_ADDR;
            end
          end else if (timer_exp) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (timer_exp && !i_Rx_DV) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else if (data_vld) begin
            pend_vld_q <= pend_vld_q & i_Rx_DV;
            if (pend_vld_q && i_Rx_DV) pend_byte_q <= i_Rx_Byte;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == LAST_LANE) begin
              wdata_q <= {data_byte, word_q};
              req_q   <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              word_q <= {data_byte, word_q[23:8]};
            end
          end
        end
        ST_WRITE: begin
          if (i_Rx_DV && pend_vld_q) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            req_q   <= 1'b0;
          end else begin
            if (i_Rx_DV) begin
              pend_vld_q  <= 1'b1;
              pend_byte_q <= i_Rx_Byte;
            end
            if (i_Mem_Ack) begin
              req_q   <= 1'b0;
              count_q <= count_inc;
              addr_q  <= addr_q + ADDR_W'(1);
              if (count_inc == len_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          req_q <= 1'b0;
          if (i_Start) begin
            state_q    <= ST_SYNC;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            hold_q     <= 1'b1;
            pend_vld_q <= 1'b0;
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign o_Mem_Req    = req_q;
  assign o_Mem_Addr   = addr_q;
  assign o_Mem_Wdata  = wdata_q;
  assign o_Cpu_Hold   = hold_q;
  assign o_Done       = done_q;
  assign o_Error      = error_q;
  assign o_Word_Count = count_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a stream-level reference model queues the
// expected IMEM writes, and an independent memory responder pops and compares them.
module tb_uart_boot_loader;

  localparam int unsigned       ADDR_W = 10;
  localparam logic [ADDR_W-1:0] BASE   = '0;
  localparam int unsigned       TMO    = 100;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              rx_dv = 1'b0, start = 1'b0, ack = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              mem_req, cpu_hold, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [15:0]       word_count;

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .i_Start(start), .o_Mem_Req(mem_req), .o_Mem_Addr(mem_addr),
    .o_Mem_Wdata(mem_wdata), .i_Mem_Ack(ack), .o_Cpu_Hold(cpu_hold),
    .o_Done(done), .o_Error(error), .o_Word_Count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  ack_delay = 0;
  int  n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Memory responder and write monitor.
  initial begin : monitor
    int held;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0] s_data;
    wr_t e;
    held = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (held == 0) begin
          s_addr = mem_addr;
          s_data = mem_wdata;
        end else begin
          check("req_addr_stable", 64'(mem_addr), 64'(s_addr));
          check("req_data_stable", 64'(mem_wdata), 64'(s_data));
        end
        if (held >= ack_delay && !ack) begin
          ack = 1'b1;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", 64'(mem_addr), 64'(e.addr));
            check("write_data", 64'(mem_wdata), 64'(e.data));
          end
        end
        held++;
      end else begin
        held = 0;
        ack  = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_dv = 1'b1;
    rx_byte = b;
    tick(1);
    rx_dv = 1'b0;
    tick(gap);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic [15:0] c);
    check({tag, "_done"}, 64'(done), 64'(d));
    check({tag, "_error"}, 64'(error), 64'(e));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(!d));
    check({tag, "_count"}, 64'(word_count), 64'(c));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check_status("after_start", 1'b0, 1'b0, 16'd0);
  endtask

  // Reference model: find the frame in the stream and derive the writes and outcome.
  task automatic model(input logic [7:0] s[$], output logic d, output logic e, output logic [15:0] c);
    int i;
    int len;
    wr_t x;
    d = 1'b0; e = 1'b0; c = 16'd0; i = 0;
    while (i < s.size() && s[i] != 8'hA5) i++;
    if (i + 2 >= s.size()) return;
    len = int'(s[i+1]) * 256 + int'(s[i+2]);
    i += 3;
    if (len == 0) begin
      d = 1'b1;
      return;
    end
    if (len > (1 << ADDR_W)) begin
      e = 1'b1;
      return;
    end
    for (int w = 0; w < len && i + 3 < s.size(); w++) begin
      x.addr = ADDR_W'(int'(BASE) + w);
      x.data = 32'(s[i]) + 32'(s[i+1]) * 256 + 32'(s[i+2]) * 65536 + 32'(s[i+3]) * 16777216;
      exp_q.push_back(x);
      c++;
      i += 4;
    end
    d = (int'(c) == len);
  endtask

  task automatic run_stream(input string tag, input logic [7:0] s[$]);
    logic d, e;
    logic [15:0] c;
    model(s, d, e, c);
    foreach (s[k]) send(s[k], $urandom_range(4, 8));
    tick(ack_delay + 12);
    check_status(tag, d, e, c);
    check({tag, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
    if (d || e) pulse_start();
  endtask

  initial begin : stimulus
    logic [7:0] st[$];
    logic d, e;
    logic [15:0] c;
    int t;

    // Reset state
    tick(2);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'(BASE));
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check_status("rst", 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    tick(2);

    // Two-word image, ack in the same cycle as req
    ack_delay = 0;
    st = {8'h00, 8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_stream("two_words", st);

    // Empty image completes with no write
    st = {8'hA5, 8'h00, 8'h00};
    run_stream("len_zero", st);

    // One word more than IMEM holds
    st = {8'hA5, 8'h04, 8'h01};
    run_stream("len_over", st);

    // Largest legal length header is accepted (then abandoned by timeout)
    send(8'hA5, 4); send(8'h04, 4); send(8'h00, 4);
    check("len_max_no_error", 64'(error), 64'd0);
    tick(TMO + 2);
    check("len_max_timeout", 64'(error), 64'd1);
    pulse_start();

    // Slow ack with a byte skidded during the write
    ack_delay = 50;
    st = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model(st, d, e, c);
    for (int k = 0; k < 6; k++) send(st[k], 4);
    send(st[6], 5);
    send(st[7], 0);
    check("skid_req_held", 64'(mem_req), 64'd1);
    check("skid_count_before_ack", 64'(word_count), 64'd0);
    t = 0;
    while (mem_req && t < 200) begin
      tick(1);
      t++;
    end
    check("skid_req_released", 64'(mem_req), 64'd0);
    check("skid_count_after_ack", 64'(word_count), 64'd1);
    for (int k = 8; k < 11; k++) send(st[k], 4);
    tick(70);
    check_status("skid", d, e, c);
    check("skid_exp_empty", 64'(exp_q.size()), 64'd0);
    pulse_start();

    // Overrun: two bytes during one write
    send(8'hA5, 4); send(8'h00, 4); send(8'h02, 4);
    send(8'h01, 4); send(8'h02, 4); send(8'h03, 4);
    send(8'h04, 3); send(8'h05, 3); send(8'h06, 3);
    check_status("overrun", 1'b0, 1'b1, 16'd0);
    check("overrun_req_dropped", 64'(mem_req), 64'd0);
    pulse_start();
    ack_delay = 0;

    // Byte arriving on the expiry cycle beats the timeout
    st = {8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    model(st, d, e, c);
    send(st[0], 4); send(st[1], 4); send(st[2], 4); send(st[3], 4); send(st[4], 0);
    tick(TMO - 1);
    send(st[5], 4);
    check("tmo_edge_no_error", 64'(error), 64'd0);
    send(st[6], 8);
    check_status("tmo_edge", d, e, c);
    pulse_start();

    // Stall after two data bytes expires exactly at TIMEOUT_CLKS
    send(8'hA5, 4); send(8'h00, 4); send(8'h01, 4); send(8'h11, 4); send(8'h22, 0);
    tick(TMO - 1);
    check("tmo_before", 64'(error), 64'd0);
    tick(1);
    check_status("tmo_expired", 1'b0, 1'b1, 16'd0);
    pulse_start();

    // Async reset mid-DATA, then a clean reload
    send(8'hA5, 4); send(8'h00, 4); send(8'h02, 4); send(8'h01, 4); send(8'h02, 2);
    rst_n = 1'b0;
    #2;
    check("arst_req", 64'(mem_req), 64'd0);
    check("arst_addr", 64'(mem_addr), 64'(BASE));
    check("arst_wdata", 64'(mem_wdata), 64'd0);
    check_status("arst", 1'b0, 1'b0, 16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    st = {8'hA5, 8'h00, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    run_stream("after_arst", st);

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int len;
      int sel;
      ack_delay = $urandom_range(0, 3);
      st = {};
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] j;
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h5A;
        st.push_back(j);
      end
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(1025, 65535);
      else len = $urandom_range(1, 6);
      st.push_back(8'hA5);
      st.push_back(8'(len / 256));
      st.push_back(8'(len % 256));
      if (len <= 6) repeat (len * 4) st.push_back(8'($urandom_range(0, 255)));
      run_stream("rand", st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Controller that sequences the UART receive path to load a program image into instruction memory before the MIPS core runs. It consumes byte strobes from the UART receiver and parses a framed stream: sync byte, 16-bit word count, then little-endian 32-bit words. Each completed word is written into IMEM through a req/ack write port. The core is held in reset until the load completes.

Parameters:
ADDR_W, 10, IMEM word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written (ADDR_W bits)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 807300, max clocks between bytes inside a frame (about 10 byte times at 9600 baud, 77.5 MHz)

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle byte-valid strobe from UART receiver
i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1
i_Start  in  1  one-cycle pulse; re-arms loader from DONE/ERROR
o_Mem_Req  out  1  IMEM write request; held until ack
o_Mem_Addr  out  ADDR_W  IMEM word address
o_Mem_Wdata  out  32  IMEM write data
i_Mem_Ack  in  1  IMEM write accepted (may be same cycle as req)
o_Cpu_Hold  out  1  1 = hold core in reset
o_Done  out  1  level; image loaded successfully
o_Error  out  1  level; frame aborted
o_Word_Count  out  16  words written in current/last frame

Behaviour:
- Async reset (i_Rst_n=0): state=SYNC, o_Mem_Req=0, o_Mem_Addr=BASE_ADDR, o_Mem_Wdata=0, o_Cpu_Hold=1, o_Done=0, o_Error=0, o_Word_Count=0, timer=0, pending buffer empty. Reset mid-frame discards all progress.
- States: SYNC, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- SYNC: DV with byte==SYNC_BYTE -> LEN_HI; other bytes ignored. No timeout.
- LEN_HI: DV -> len[15:8]=byte, go LEN_LO. LEN_LO: DV -> len[7:0]=byte; if len==0 -> DONE; if len > 2^ADDR_W -> ERROR; else -> DATA, byte_idx=0, count=0, addr=BASE_ADDR.
- DATA: DV -> shift byte into word at lane byte_idx (byte 0 = bits 7:0); byte_idx wraps 3->0. On 4th byte, load o_Mem_Wdata, assert o_Mem_Req next cycle, go WRITE.
- WRITE: hold req/addr/data stable until i_Mem_Ack=1 sampled. On ack: req=0, count+1, addr+1 (wraps mod 2^ADDR_W, never reached for legal len); if count+1==len -> DONE else -> DATA.
- Skid: one-entry pending byte register. DV during WRITE stores the byte in pending; on return to DATA the pending byte is consumed first, in the cycle after ack. A second DV while pending is full -> ERROR (overrun).
- Timeout: timer is cleared on every DV and increments in LEN_HI, LEN_LO, DATA (not WRITE). At timer==TIMEOUT_CLKS-1 without DV -> ERROR.
- DONE: o_Done=1, o_Cpu_Hold=0, further DV ignored. ERROR: o_Error=1, o_Cpu_Hold=1, DV ignored, req dropped.
- i_Start in DONE or ERROR: clear Done/Error/count, set Hold=1, go SYNC. i_Start in any other state is ignored.
- Simultaneous DV and timeout expiry: DV wins and the timer clears.
- o_Word_Count is a registered copy of count; it reflects a write the cycle after its ack.

Decomposition:
- Shared package/header: state encodings (3-bit localparams), SYNC_BYTE default, frame-format constants (LEN bytes=2, bytes/word=4).
- One sub-module: boot_timeout_timer (counter with clear/enable, expiry pulse at TIMEOUT_CLKS-1). Everything else stays in a single FSM module.

Test Plan:
- Reset then bytes 00 A5 00 02 11 22 33 44 AA BB CC DD with ack same cycle -> writes addr0=44332211 and addr1=DDCCBBAA; o_Done=1, o_Cpu_Hold=0, o_Word_Count=2.
- A5 00 00 -> DONE immediately with no o_Mem_Req pulse; then i_Start -> Hold=1, Done=0, back in SYNC.
- Length 0x0401 with ADDR_W=10 -> ERROR after LEN_LO; o_Error=1, o_Cpu_Hold stays 1, no writes.
- Ack delayed 50 cycles with next byte arriving during WRITE -> req/addr/data stable for 50 cycles; pending byte lands in lane 0 of the next word. A third byte (second DV while pending full) during the same WRITE -> ERROR.
- Stall after 2 data bytes for TIMEOUT_CLKS (set to 100 in bench) -> ERROR at cycle 100; a byte arriving at cycle 99 instead -> no error.
- Assert i_Rst_n=0 mid-DATA -> all outputs return to reset values immediately (async); a following full frame loads correctly from BASE_ADDR.
